// File: rtl/process_dispatcher.sv
// process_dispatcher: saves the trapped PC of the running process, picks the
// next ready process round-robin when the OS switch routine returns, reloads
// its PC and produces the per-slice retired-instruction count.

// One process-table entry: valid bit plus stored PC.
module proc_slot #(
    parameter int PC_W = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            trap_hit,
    input  logic            trap_end,
    input  logic [PC_W-1:0] trap_pc,
    input  logic            start_hit,
    input  logic [PC_W-1:0] start_pc,
    output logic            valid,
    output logic [PC_W-1:0] pc,
    output logic            err
);

    logic post_valid;

    // A trap on this slot is applied first; a start then sees the result.
    always_comb begin
        post_valid = valid;
        if (trap_hit && trap_end)
            post_valid = 1'b0;
        err = start_hit && post_valid;
    end

    // Install a new process, or record the trap save/invalidate.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            pc    <= '0;
        end else if (start_hit && !post_valid) begin
            valid <= 1'b1;
            pc    <= start_pc;
        end else if (trap_hit) begin
            if (trap_end)
                valid <= 1'b0;
            else
                pc <= trap_pc;
        end
    end

endmodule

module process_dispatcher #(
    parameter int NPROC   = 4,
    parameter int PID_W   = 2,
    parameter int QUANTUM = 10,
    parameter int PC_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable_so,
    input  logic             end_proc,
    input  logic [PC_W-1:0]  pc_curr,
    input  logic             instr_retire,
    input  logic             os_return,
    input  logic             proc_start,
    input  logic [PID_W-1:0] proc_start_id,
    input  logic [PC_W-1:0]  proc_start_pc,
    output logic [4:0]       pc_counter,
    output logic [PC_W-1:0]  pc_resume,
    output logic             pc_load,
    output logic [PID_W-1:0] cur_pid,
    output logic             os_mode,
    output logic             idle,
    output logic             start_err
);

    localparam logic [4:0] QMAX = 5'(QUANTUM);

    typedef enum logic [1:0] {
        ST_OS     = 2'd0,
        ST_SELECT = 2'd1,
        ST_RESUME = 2'd2,
        ST_USER   = 2'd3
    } state_t;

    state_t                       state;
    logic [PID_W-1:0]             last_pid;
    logic                         trap_fire;
    logic [NPROC-1:0]             slot_valid;
    logic [NPROC-1:0]             slot_err;
    logic [NPROC-1:0][PC_W-1:0]   slot_pc;
    logic                         found;
    logic [PID_W-1:0]             win;
    logic [PID_W-1:0]             idx;

    assign trap_fire = (state == ST_USER) && enable_so;

    generate
        for (genvar g = 0; g < NPROC; g++) begin : g_slot
            proc_slot #(.PC_W(PC_W)) u_slot (
                .clock     (clock),
                .reset     (reset),
                .trap_hit  (trap_fire && (cur_pid == PID_W'(g))),
                .trap_end  (end_proc),
                .trap_pc   (pc_curr),
                .start_hit (proc_start && (proc_start_id == PID_W'(g))),
                .start_pc  (proc_start_pc),
                .valid     (slot_valid[g]),
                .pc        (slot_pc[g]),
                .err       (slot_err[g])
            );
        end
    endgenerate

    // Round-robin search from last_pid+1; descending loop so the nearest
    // valid slot wins and last_pid itself has the lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = NPROC; i >= 1; i--) begin
            idx = last_pid + PID_W'(i);
            if (slot_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Dispatch FSM with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_OS;
            last_pid   <= PID_W'(NPROC - 1);
            cur_pid    <= '0;
            pc_resume  <= '0;
            pc_load    <= 1'b0;
            pc_counter <= '0;
            os_mode    <= 1'b1;
            idle       <= 1'b0;
        end else begin
            case (state)
                ST_OS: begin
                    if (os_return)
                        state <= ST_SELECT;
                end
                ST_SELECT: begin
                    if (found) begin
                        cur_pid    <= win;
                        last_pid   <= win;
                        pc_resume  <= slot_pc[win];
                        idle       <= 1'b0;
                        pc_load    <= 1'b1;
                        os_mode    <= 1'b0;
                        pc_counter <= '0;
                        state      <= ST_RESUME;
                    end else begin
                        idle  <= 1'b1;
                        state <= ST_OS;
                    end
                end
                ST_RESUME: begin
                    pc_load <= 1'b0;
                    state   <= ST_USER;
                end
                ST_USER: begin
                    if (enable_so) begin
                        os_mode <= 1'b1;
                        state   <= ST_OS;
                    end else if (instr_retire && (pc_counter < QMAX)) begin
                        pc_counter <= pc_counter + 5'd1;
                    end
                end
                default: state <= ST_OS;
            endcase
        end
    end

    // One-cycle error pulse for a start aimed at an occupied slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            start_err <= 1'b0;
        else
            start_err <= |slot_err;
    end

    a_load_not_os: assert property (@(posedge clock) disable iff (!reset)
        !(pc_load && os_mode));
    a_load_single: assert property (@(posedge clock) disable iff (!reset)
        !(pc_load && $past(pc_load)));

endmodule

// File: tb/tb_process_dispatcher.sv
// Directed bench for process_dispatcher: dispatch latency, quantum
// saturation, round-robin order, termination, idle, start errors and reset.
module tb_process_dispatcher;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable_so = 1'b0;
    logic        end_proc = 1'b0;
    logic [31:0] pc_curr = '0;
    logic        instr_retire = 1'b0;
    logic        os_return = 1'b0;
    logic        proc_start = 1'b0;
    logic [1:0]  proc_start_id = '0;
    logic [31:0] proc_start_pc = '0;
    logic [4:0]  pc_counter;
    logic [31:0] pc_resume;
    logic        pc_load;
    logic [1:0]  cur_pid;
    logic        os_mode;
    logic        idle;
    logic        start_err;

    int n_tests = 0;
    int n_fail  = 0;

    process_dispatcher #(.NPROC(4), .PID_W(2), .QUANTUM(10), .PC_W(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable_so     (enable_so),
        .end_proc      (end_proc),
        .pc_curr       (pc_curr),
        .instr_retire  (instr_retire),
        .os_return     (os_return),
        .proc_start    (proc_start),
        .proc_start_id (proc_start_id),
        .proc_start_pc (proc_start_pc),
        .pc_counter    (pc_counter),
        .pc_resume     (pc_resume),
        .pc_load       (pc_load),
        .cur_pid       (cur_pid),
        .os_mode       (os_mode),
        .idle          (idle),
        .start_err     (start_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic start(input logic [1:0] id, input logic [31:0] pc);
        proc_start = 1'b1; proc_start_id = id; proc_start_pc = pc;
        step();
        proc_start = 1'b0;
    endtask

    task automatic trap(input logic [31:0] pc, input logic fin);
        enable_so = 1'b1; pc_curr = pc; end_proc = fin;
        step();
        enable_so = 1'b0; end_proc = 1'b0;
    endtask

    // os_return, then SELECT; returns positioned in RESUME (or OS if idle).
    task automatic dispatch();
        os_return = 1'b1;
        step();
        os_return = 1'b0;
        step();
    endtask

    task automatic exp_resume(input string tag, input logic [1:0] pid, input logic [31:0] pc);
        chk({tag, "_load"}, 32'(pc_load), 32'd1);
        chk({tag, "_pc"}, pc_resume, pc);
        chk({tag, "_pid"}, 32'(cur_pid), 32'(pid));
        chk({tag, "_osm"}, 32'(os_mode), 32'd0);
        step();
        chk({tag, "_ld0"}, 32'(pc_load), 32'd0);
    endtask

    initial begin
        // reset values
        #12;
        chk("rst_osm", 32'(os_mode), 32'd1);
        chk("rst_load", 32'(pc_load), 32'd0);
        chk("rst_cnt", 32'(pc_counter), 32'd0);
        chk("rst_pc", pc_resume, 32'd0);
        chk("rst_pid", 32'(cur_pid), 32'd0);
        chk("rst_idle", 32'(idle), 32'd0);
        chk("rst_err", 32'(start_err), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        step();

        // 1: first dispatch and latency
        start(2'd0, 32'h100);
        start(2'd1, 32'h200);
        chk("t1_err", 32'(start_err), 32'd0);
        os_return = 1'b1;
        step();
        os_return = 1'b0;
        chk("t1_sel_load", 32'(pc_load), 32'd0);
        chk("t1_sel_osm", 32'(os_mode), 32'd1);
        step();
        exp_resume("t1", 2'd0, 32'h100);

        // 2: saturation, round robin, trap-cycle retire ignored
        instr_retire = 1'b1;
        repeat (12) step();
        instr_retire = 1'b0;
        chk("t2_sat", 32'(pc_counter), 32'd10);
        trap(32'h128, 1'b0);
        chk("t2_osm", 32'(os_mode), 32'd1);
        chk("t2_hold", 32'(pc_counter), 32'd10);
        dispatch();
        exp_resume("t2a", 2'd1, 32'h200);
        chk("t2_clr", 32'(pc_counter), 32'd0);
        instr_retire = 1'b1;
        repeat (3) step();
        trap(32'h1a0, 1'b0);
        instr_retire = 1'b0;
        chk("t2_trapcnt", 32'(pc_counter), 32'd3);
        dispatch();
        exp_resume("t2b", 2'd0, 32'h128);

        // 3: terminate pid1, dispatches stay on pid0
        trap(32'h130, 1'b0);
        dispatch();
        exp_resume("t3a", 2'd1, 32'h1a0);
        trap(32'h0, 1'b1);
        dispatch();
        exp_resume("t3b", 2'd0, 32'h130);
        trap(32'h140, 1'b0);
        dispatch();
        exp_resume("t3c", 2'd0, 32'h140);

        // 5: start to occupied slot, then trap-end + start on same edge
        trap(32'h150, 1'b0);
        start(2'd0, 32'h999);
        chk("t5_err1", 32'(start_err), 32'd1);
        step();
        chk("t5_err0", 32'(start_err), 32'd0);
        dispatch();
        exp_resume("t5a", 2'd0, 32'h150);
        proc_start = 1'b1; proc_start_id = 2'd0; proc_start_pc = 32'h400;
        trap(32'h777, 1'b1);
        proc_start = 1'b0;
        chk("t5_err2", 32'(start_err), 32'd0);
        dispatch();
        exp_resume("t5b", 2'd0, 32'h400);

        // 6: reset during RESUME
        trap(32'h410, 1'b0);
        dispatch();
        chk("t6_inres", 32'(pc_load), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_load", 32'(pc_load), 32'd0);
        chk("t6_osm", 32'(os_mode), 32'd1);
        chk("t6_pc", pc_resume, 32'd0);
        chk("t6_pid", 32'(cur_pid), 32'd0);
        step();
        reset = 1'b1;
        step();

        // 4: empty table goes idle, then a new process clears it
        dispatch();
        chk("t4_idle", 32'(idle), 32'd1);
        chk("t4_load", 32'(pc_load), 32'd0);
        chk("t4_osm", 32'(os_mode), 32'd1);
        step();
        chk("t4_osm2", 32'(os_mode), 32'd1);
        start(2'd2, 32'h300);
        dispatch();
        chk("t4_idle0", 32'(idle), 32'd0);
        exp_resume("t4", 2'd2, 32'h300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
